i2s_rx: RTL and testbench

- I2S master receiver for the PmodI2S2 line-in (ADC) connector. It is the capture-side counterpart of the existing I2S DAC output path.
- It generates MCLK, LRCK and SCLK from the 100 MHz system clock and deserializes the ADC serial data into signed 16-bit left/right samples.
- Samples are offered on a one-deep valid/ready output register, with sticky overrun detection.
- Downstream consumers are the sample store and the signal mixer.

---
 rtl/i2s_rx.sv | 107 ++++++++++
 tb/tb_i2s_rx.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx.sv
// I2S master receiver: makes MCLK/SCLK/LRCK from clk and captures 16-bit L/R words into a one-deep valid/ready register.
// out_valid rises 4 clk after the right-word LSB SCLK edge; an unaccepted pair is overwritten and flags sticky overrun.
module i2s_rx #(
    parameter int SCLK_DIV = 16,
    parameter int MCLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        sd_in,
    output logic        mclk,
    output logic        lrck,
    output logic        sclk,
    output logic [15:0] sample_l,
    output logic [15:0] sample_r,
    output logic [15:0] sample_mono,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        overrun,
    input  logic        overrun_clr
);
    localparam int CNT_W = $clog2(64 * SCLK_DIV);
    localparam int PH_W  = $clog2(SCLK_DIV);
    localparam int MC_W  = $clog2(MCLK_DIV);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [PH_W-1:0]  phase;
    logic [5:0]       bit_idx;
    logic [1:0]       sync_q;
    logic [15:0]      shl;
    logic [15:0]      shr;
    logic             load_pend;
    logic             strobe;
    logic             cap_l;
    logic             cap_r;
    logic [16:0]      sum;
    logic [15:0]      mono;

    assign phase   = cnt[PH_W-1:0];
    assign bit_idx = cnt[CNT_W-1:PH_W];

    // Two clk of synchronizer latency after the SCLK rising edge at phase SCLK_DIV/2.
    assign strobe = en && (phase == PH_W'(SCLK_DIV / 2 + 2));
    assign cap_l  = strobe && (bit_idx >= 6'd1)  && (bit_idx <= 6'd16);
    assign cap_r  = strobe && (bit_idx >= 6'd33) && (bit_idx <= 6'd48);

    assign sum  = {shl[15], shl} + {shr[15], shr};
    assign mono = 16'(sum >> 1);

    always_comb begin
        cnt_nxt = '0;
        if (en) begin
            cnt_nxt = cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt         <= '0;
            mclk        <= 1'b0;
            lrck        <= 1'b0;
            sclk        <= 1'b0;
            sync_q      <= '0;
            shl         <= '0;
            shr         <= '0;
            load_pend   <= 1'b0;
            sample_l    <= '0;
            sample_r    <= '0;
            sample_mono <= '0;
            out_valid   <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            // Interface clocks are decoded from the next count so they line up with cnt.
            cnt    <= cnt_nxt;
            sclk   <= cnt_nxt[PH_W-1];
            mclk   <= cnt_nxt[MC_W-1];
            lrck   <= cnt_nxt[CNT_W-1];
            sync_q <= {sync_q[0], sd_in};

            if (!en) begin
                shl <= '0;
                shr <= '0;
            end else begin
                if (cap_l) shl <= {shl[14:0], sync_q[1]};
                if (cap_r) shr <= {shr[14:0], sync_q[1]};
            end

            load_pend <= cap_r && (bit_idx == 6'd48);

            if (load_pend) begin
                sample_l    <= shl;
                sample_r    <= shr;
                sample_mono <= mono;
                out_valid   <= 1'b1;
            end else if (out_ready) begin
                out_valid   <= 1'b0;
            end

            if (load_pend && out_valid && !out_ready) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_i2s_rx.sv
// Directed self-checking bench for i2s_rx with a behavioural I2S ADC driving sd_in.
`timescale 1ns/1ps
module tb_i2s_rx;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        sd_in = 1'b0;
    logic        out_ready = 1'b0;
    logic        overrun_clr = 1'b0;
    logic        mclk, lrck, sclk, out_valid, overrun;
    logic [15:0] sample_l, sample_r, sample_mono;

    int checks = 0;
    int errors = 0;

    logic [15:0] adc_l = '0;
    logic [15:0] adc_r = '0;
    logic [7:0]  lo_l = '0;
    logic [7:0]  lo_r = '0;
    int          bitpos = 0;
    logic        prev_lrck = 1'b0;
    time         t_lsb = 0;

    i2s_rx dut (
        .clk(clk), .rst_n(rst_n), .en(en), .sd_in(sd_in),
        .mclk(mclk), .lrck(lrck), .sclk(sclk),
        .sample_l(sample_l), .sample_r(sample_r), .sample_mono(sample_mono),
        .out_valid(out_valid), .out_ready(out_ready),
        .overrun(overrun), .overrun_clr(overrun_clr)
    );

    always #5 clk = ~clk;

    function automatic logic bit_value(input int b);
        logic [23:0] lw;
        logic [23:0] rw;
        lw = {adc_l, lo_l};
        rw = {adc_r, lo_r};
        if (b >= 1 && b <= 24) return lw[24-b];
        if (b >= 33 && b <= 56) return rw[56-b];
        return 1'b0;
    endfunction

    // ADC model: 24-bit words, MSB one SCLK after the LRCK edge, data changes on SCLK falling edges.
    always @(negedge sclk or negedge en or negedge rst_n) begin
        #1;
        if (!en || !rst_n) begin
            bitpos    = 0;
            prev_lrck = 1'b0;
        end else begin
            if (lrck != prev_lrck) bitpos = lrck ? 32 : 0;
            else bitpos = bitpos + 1;
            prev_lrck = lrck;
        end
        sd_in = bit_value(bitpos);
    end

    always @(posedge sclk) begin
        if (bitpos == 48) t_lsb = $time;
    end

    task automatic set_words(input logic [15:0] l, input logic [15:0] r);
        adc_l = l;
        adc_r = r;
        lo_l  = 8'($urandom_range(0, 255));
        lo_r  = 8'($urandom_range(0, 255));
    endtask

    task automatic sync_frame;
        logic p;
        int   n;
        p = lrck;
        n = 0;
        while (n < 2100) begin
            @(posedge clk); #1;
            if (p && !lrck) break;
            p = lrck;
            n++;
        end
        checks++;
        if (n >= 2100) begin
            errors++;
            $display("FAIL sync_frame: lrck fall not seen, waited %0d cycles (limit 2100)", n);
        end
    endtask

    task automatic wait_valid(output logic ok, output time tv);
        int n;
        ok = 1'b0;
        tv = 0;
        n  = 0;
        while (n < 2100 && !ok) begin
            @(posedge clk); #1;
            if (out_valid) begin
                ok = 1'b1;
                tv = $time - 1;
            end
            n++;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1; en = 1'b1;
        repeat (700) @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({mclk, lrck, sclk} !== 3'b000) begin
            errors++; $display("FAIL reset_clocks: got %b expected 000", {mclk, lrck, sclk});
        end
        checks++;
        if ({sample_l, sample_r, sample_mono} !== 48'h0) begin
            errors++; $display("FAIL reset_samples: got %h %h %h expected 0", sample_l, sample_r, sample_mono);
        end
        checks++;
        if ({out_valid, overrun} !== 2'b00) begin
            errors++; $display("FAIL reset_flags: got %b expected 00", {out_valid, overrun});
        end
    endtask

    task automatic test_waveform;
        int bad_s, bad_m, bad_l, rise_k;
        logic pl;
        bad_s = 0; bad_m = 0; bad_l = 0; rise_k = -1; pl = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        for (int k = 0; k < 1100; k++) begin
            @(posedge clk); #1;
            if (sclk !== (((k + 1) % 16) >= 8)) bad_s++;
            if (mclk !== (((k + 1) % 4) >= 2)) bad_m++;
            if (lrck !== (((k + 1) % 1024) >= 512)) bad_l++;
            if (lrck && !pl && rise_k < 0) rise_k = k;
            pl = lrck;
        end
        checks++;
        if (bad_s != 0) begin errors++; $display("FAIL sclk_wave: %0d bad cycles, expected 0", bad_s); end
        checks++;
        if (bad_m != 0) begin errors++; $display("FAIL mclk_wave: %0d bad cycles, expected 0", bad_m); end
        checks++;
        if (bad_l != 0) begin errors++; $display("FAIL lrck_wave: %0d bad cycles, expected 0", bad_l); end
        checks++;
        if (rise_k != 511) begin errors++; $display("FAIL lrck_rise: at cnt %0d expected 512", rise_k + 1); end
    endtask

    task automatic test_capture;
        logic ok;
        time  tv;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        sync_frame();
        set_words(16'h8001, 16'h7FFE);
        wait_valid(ok, tv);
        checks++;
        if (!ok) begin errors++; $display("FAIL capture_valid: out_valid=0 after 2100 cycles, expected 1"); end
        checks++;
        if (tv - t_lsb != 64'd40) begin errors++; $display("FAIL capture_latency: %0t ns expected 40 ns", tv - t_lsb); end
        checks++;
        if ({sample_l, sample_r, sample_mono} !== {16'h8001, 16'h7FFE, 16'hFFFF}) begin
            errors++; $display("FAIL capture_data: got %h %h %h expected 8001 7ffe ffff", sample_l, sample_r, sample_mono);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL capture_pulse: out_valid=%b expected 0", out_valid); end
    endtask

    task automatic test_mono;
        logic ok;
        time  tv;
        logic [15:0] l, r, m;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: begin l = 16'h7FFF; r = 16'h7FFF; m = 16'h7FFF; end
                1: begin l = 16'h8000; r = 16'h8000; m = 16'h8000; end
                default: begin l = 16'h0003; r = 16'h0000; m = 16'h0001; end
            endcase
            sync_frame();
            set_words(l, r);
            wait_valid(ok, tv);
            checks++;
            if (!ok || sample_mono !== m) begin
                errors++; $display("FAIL mono_%0d: got %h (valid %b) expected %h", i, sample_mono, ok, m);
            end
        end
    endtask

    task automatic test_overrun;
        logic ok;
        time  tv;
        out_ready = 1'b0;
        sync_frame();
        set_words(16'h1111, 16'h0000);
        wait_valid(ok, tv);
        sync_frame();
        set_words(16'h2222, 16'h0000);
        repeat (784) @(posedge clk);
        #1;
        checks++;
        if ({overrun, out_valid} !== 2'b11) begin
            errors++; $display("FAIL overrun_set: overrun/valid %b expected 11", {overrun, out_valid});
        end
        checks++;
        if (sample_l !== 16'h2222) begin errors++; $display("FAIL overrun_data: got %h expected 2222", sample_l); end
        @(negedge clk); overrun_clr = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({overrun, out_valid} !== 2'b01) begin
            errors++; $display("FAIL overrun_clr: overrun/valid %b expected 01", {overrun, out_valid});
        end
        @(negedge clk); overrun_clr = 1'b0; out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic ok;
        time  tv;
        int   n;
        sync_frame();
        set_words(16'h3333, 16'h0000);
        wait_valid(ok, tv);
        sync_frame();
        set_words(16'h4444, 16'h0000);
        n = 0;
        while (n < 1100) begin
            @(posedge clk); #1;
            if (sclk && bitpos == 48) break;
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, sample_l} !== {1'b1, 16'h3333}) begin
            errors++; $display("FAIL b2b_pending: valid %b data %h expected 1 3333", out_valid, sample_l);
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({out_valid, overrun, sample_l} !== {1'b1, 1'b0, 16'h4444}) begin
            errors++; $display("FAIL b2b_load: valid %b overrun %b data %h expected 1 0 4444", out_valid, overrun, sample_l);
        end
        @(negedge clk); out_ready = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_hold: out_valid=%b expected 1", out_valid); end
        @(negedge clk); out_ready = 1'b1;
    endtask

    task automatic test_enable_abort;
        logic ok;
        time  tv;
        int   n, bad, rise_k;
        logic pl;
        sync_frame();
        set_words(16'h5555, 16'h6666);
        n = 0;
        while (n < 1100 && bitpos != 40) begin
            @(posedge clk); #1;
            n++;
        end
        @(negedge clk); en = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({mclk, lrck, sclk} !== 3'b000) begin
            errors++; $display("FAIL abort_clocks: got %b expected 000", {mclk, lrck, sclk});
        end
        bad = 0;
        for (int k = 0; k < 1100; k++) begin
            @(posedge clk); #1;
            if (out_valid || mclk || lrck || sclk) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL abort_idle: %0d active cycles, expected 0", bad); end
        set_words(16'h0A0B, 16'hF0F0);
        @(negedge clk); en = 1'b1;
        rise_k = -1; pl = 1'b0;
        for (int k = 0; k < 600; k++) begin
            @(posedge clk); #1;
            if (lrck && !pl && rise_k < 0) rise_k = k;
            pl = lrck;
        end
        checks++;
        if (rise_k != 511) begin errors++; $display("FAIL abort_restart: lrck rose at cnt %0d expected 512", rise_k + 1); end
        wait_valid(ok, tv);
        checks++;
        if (!ok || {sample_l, sample_r} !== {16'h0A0B, 16'hF0F0}) begin
            errors++; $display("FAIL abort_capture: valid %b data %h %h expected 0a0b f0f0", ok, sample_l, sample_r);
        end
    endtask

    initial begin
        test_reset();
        test_waveform();
        test_capture();
        test_mono();
        test_overrun();
        test_back_to_back();
        test_enable_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
